// File: rtl/midori_round_linear_if.sv
// Bus between the Midori-128 datapath and the linear/round-key stage.
// Signals:
//   in_valid  : capture request for state_in/key/round_idx
//   round_idx : round number (1..19 select beta0..beta18, others give zero constant)
//   key       : 128-bit master key
//   state_in  : state after SubCell
//   out_valid : state_out/sub_key hold a new result
//   state_out : MC(SH(state_in)) ^ RK
//   sub_key   : round key used for the captured operation
// master drives the request side, slave is the linear stage itself.
interface midori_round_linear_if;
    logic         in_valid;
    logic [4:0]   round_idx;
    logic [127:0] key;
    logic [127:0] state_in;
    logic         out_valid;
    logic [127:0] state_out;
    logic [127:0] sub_key;

    modport master (
        output in_valid, round_idx, key, state_in,
        input  out_valid, state_out, sub_key
    );

    modport slave (
        input  in_valid, round_idx, key, state_in,
        output out_valid, state_out, sub_key
    );
endinterface

// File: rtl/midori_round_linear.sv
// Midori-128 ShuffleCell + MixColumn + round-key XOR, one registered stage.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears all outputs
//   bus   : midori_round_linear_if.slave (request inputs, registered results)
// Cell j occupies bits [127-8j -: 8]; column c holds cells 4c..4c+3.
module midori_round_linear (
    input  logic                       clk,
    input  logic                       rst_n,
    midori_round_linear_if.slave       bus
);
    localparam int unsigned SW    = 128;
    localparam int unsigned CW    = 8;
    localparam int unsigned CELLS = 16;
    localparam int unsigned BW    = 16;

    // ShuffleCell source cell for each destination cell, entry 0 in the MSB nibble
    localparam logic [63:0] PERM = {
        4'd0,  4'd10, 4'd5,  4'd15, 4'd14, 4'd4,  4'd11, 4'd1,
        4'd9,  4'd3,  4'd12, 4'd6,  4'd7,  4'd13, 4'd2,  4'd8
    };

    logic [BW-1:0] beta_c;
    logic [SW-1:0] rk_c;
    logic [SW-1:0] sh_c;
    logic [SW-1:0] mc_c;

    // Round constant; indices outside 1..19 yield zero (whitening key)
    always_comb begin
        beta_c = '0;
        case (bus.round_idx)
            5'd1:    beta_c = 16'h15B3;
            5'd2:    beta_c = 16'h78C0;
            5'd3:    beta_c = 16'hA435;
            5'd4:    beta_c = 16'h6213;
            5'd5:    beta_c = 16'h104F;
            5'd6:    beta_c = 16'hD170;
            5'd7:    beta_c = 16'h0266;
            5'd8:    beta_c = 16'h0BCC;
            5'd9:    beta_c = 16'h9481;
            5'd10:   beta_c = 16'h40B8;
            5'd11:   beta_c = 16'h7197;
            5'd12:   beta_c = 16'h228E;
            5'd13:   beta_c = 16'h5130;
            5'd14:   beta_c = 16'hF8CA;
            5'd15:   beta_c = 16'hDF90;
            5'd16:   beta_c = 16'h7C81;
            5'd17:   beta_c = 16'h1C24;
            5'd18:   beta_c = 16'h23B4;
            5'd19:   beta_c = 16'h628A;
            default: beta_c = '0;
        endcase
    end

    // Key generation: beta bit (15-j) lands on the LSB of cell j
    always_comb begin
        rk_c = bus.key;
        for (int j = 0; j < int'(CELLS); j++) begin
            rk_c[SW-CW-CW*j] = bus.key[SW-CW-CW*j] ^ beta_c[BW-1-j];
        end
    end

    // ShuffleCell: out[i] = in[PERM[i]]
    always_comb begin
        sh_c = '0;
        for (int i = 0; i < int'(CELLS); i++) begin
            sh_c[SW-1-CW*i -: CW] = bus.state_in[SW-1-CW*int'(PERM[63-4*i -: 4]) -: CW];
        end
    end

    // MixColumn: each cell becomes column parity XOR itself (= XOR of the other three)
    always_comb begin
        logic [CW-1:0] par;
        mc_c = '0;
        for (int c = 0; c < 4; c++) begin
            par = sh_c[SW-1-CW*(4*c)   -: CW] ^ sh_c[SW-1-CW*(4*c+1) -: CW]
                ^ sh_c[SW-1-CW*(4*c+2) -: CW] ^ sh_c[SW-1-CW*(4*c+3) -: CW];
            for (int r = 0; r < 4; r++) begin
                mc_c[SW-1-CW*(4*c+r) -: CW] = par ^ sh_c[SW-1-CW*(4*c+r) -: CW];
            end
        end
    end

    // Output stage: results load on in_valid and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.state_out <= '0;
            bus.sub_key   <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.state_out <= mc_c ^ rk_c;
                bus.sub_key   <= rk_c;
            end
        end
    end
endmodule

// File: tb/tb_midori_round_linear.sv
// Self-checking bench for midori_round_linear: directed vectors plus random
// traffic checked against a byte-array reference model.
module tb_midori_round_linear;
    logic clk;
    logic rst_n;

    midori_round_linear_if bus ();

    midori_round_linear dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int          perm [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
    logic [15:0] betas [19] = '{16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
                                16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
                                16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90,
                                16'h7C81, 16'h1C24, 16'h23B4, 16'h628A};

    // Expected output registers
    logic         exp_valid;
    logic [127:0] exp_state;
    logic [127:0] exp_key;

    function automatic logic [127:0] ref_key(input logic [127:0] k, input int idx);
        logic [15:0]  b;
        logic [7:0]   cells [16];
        logic [127:0] res;
        b = 16'h0;
        if (idx >= 1 && idx <= 19) b = betas[idx-1];
        for (int j = 0; j < 16; j++) begin
            cells[j] = k[127-8*j -: 8];
            if (b[15-j]) cells[j] = cells[j] ^ 8'h01;
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = cells[j];
        return res;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic [127:0] rk);
        logic [7:0]   a  [16];
        logic [7:0]   sh [16];
        logic [7:0]   mc [16];
        logic [127:0] res;
        for (int j = 0; j < 16; j++) a[j] = s[127-8*j -: 8];
        for (int i = 0; i < 16; i++) sh[i] = a[perm[i]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[4*c+r] = sh[4*c+(r+1)%4] ^ sh[4*c+(r+2)%4] ^ sh[4*c+(r+3)%4];
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = mc[j];
        return res ^ rk;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 128'(bus.out_valid), 128'(exp_valid));
        check({tag, ".state"}, bus.state_out, exp_state);
        check({tag, ".key"},   bus.sub_key,   exp_key);
    endtask

    // Drive one cycle of inputs, advance past the edge, update model, compare
    task automatic step(input string tag, input logic v, input logic [4:0] idx,
                        input logic [127:0] k, input logic [127:0] s);
        logic [127:0] rk;
        bus.in_valid  = v;
        bus.round_idx = idx;
        bus.key       = k;
        bus.state_in  = s;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            rk        = ref_key(k, int'(idx));
            exp_key   = rk;
            exp_state = ref_state(s, rk);
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [127:0] rk_r, st_r;
        logic         v_r;
        logic [4:0]   idx_r;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.round_idx = 5'd0;
        bus.key       = '0;
        bus.state_in  = '0;
        exp_valid     = 1'b0;
        exp_state     = '0;
        exp_key       = '0;

        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset", 1'b0, 5'd1, '0, '0);

        step("zero_r1", 1'b1, 5'd1, '0, '0);
        check("zero_r1.lit", bus.state_out, 128'h00000001000100010100010100000101);
        step("cell0", 1'b1, 5'd0, '0, 128'h01000000000000000000000000000000);
        check("cell0.lit", bus.state_out, 128'h00010101000000000000000000000000);
        step("cell1", 1'b1, 5'd0, '0, 128'h00AB0000000000000000000000000000);
        check("cell1.lit", bus.state_out, 128'h00000000ABABAB000000000000000000);
        step("uniform_r0", 1'b1, 5'd0, '0, {16{8'h5A}});
        check("uniform_r0.lit", bus.state_out, {16{8'h5A}});
        step("uniform_r20", 1'b1, 5'd20, '0, {16{8'h5A}});
        check("uniform_r20.lit", bus.state_out, {16{8'h5A}});
        step("hold", 1'b0, 5'd3, {16{8'h11}}, {16{8'h22}});
        step("ff_r19", 1'b1, 5'd19, {16{8'hFF}}, '0);
        check("ff_r19.lit", bus.sub_key, 128'hFFFEFEFFFFFFFEFFFEFFFFFFFEFFFEFF);
        step("ff_r1_b2b", 1'b1, 5'd1, {16{8'hFF}}, '0);
        step("r31", 1'b1, 5'd31, 128'h0123456789ABCDEF0011223344556677, 128'hDEADBEEF00000000CAFEF00D12345678);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        exp_valid = 1'b0;
        exp_state = '0;
        exp_key   = '0;
        #1;
        check_outputs("async_reset");
        #1;
        rst_n = 1'b1;
        step("post_reset_idle", 1'b0, 5'd5, {16{8'hA5}}, {16{8'h3C}});
        step("post_reset_cap", 1'b1, 5'd5, {16{8'hA5}}, {16{8'h3C}});

        // Random traffic, every round index reachable
        for (int n = 0; n < 60; n++) begin
            rk_r  = {$urandom, $urandom, $urandom, $urandom};
            st_r  = {$urandom, $urandom, $urandom, $urandom};
            v_r   = ($urandom_range(0, 3) != 0);
            idx_r = 5'($urandom_range(0, 31));
            step("random", v_r, idx_r, rk_r, st_r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/midori_round_linear.md
# midori_round_linear

Registered linear-layer and round-key stage for a Midori-128 encryption core. It takes a 128-bit state (already through SubCell) plus the master key and a round index. It applies ShuffleCell, then MixColumn, then XORs the Midori-128 round key for that round, and registers the result. It sits between the S-box layer and the state register of an iterative 20-round encryptor. The sub-blocks are key generation, shuffle-cell and mix-column.

## Interface
- No parameters; widths fixed by Midori-128.
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  capture request for state_in/key/round_idx this cycle.
- round_idx  input  5  round number; 1..19 select constants β0..β18.
- key  input  128  master key K.
- state_in  input  128  state after SubCell.
- out_valid  output  1  state_out/sub_key hold a new result.
- state_out  output  128  MC(SH(state_in)) ^ RK.
- sub_key  output  128  round key RK used for the captured operation.

## Operation
- Cell convention: 16 byte cells; cell j = bits [127-8j : 120-8j], so cell 0 is the MSB byte. Column c = cells 4c..4c+3, with row = j mod 4.
- ShuffleCell: out[i] = in[P[i]], where P = (0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8).
- MixColumn, per column: out[4c+r] = XOR of the other three cells of that column, equivalently (in0^in1^in2^in3)^in[4c+r]. The operation is an involution.
- Key generation: RK = K ^ B(round_idx). B is zero except bit 0 (LSB) of cell j, which equals bit (15-j) of a 16-bit constant β.
- β0..β18 (hex, bit 15 = cell 0): 15B3, 78C0, A435, 6213, 104F, D170, 0266, 0BCC, 9481, 40B8, 7197, 228E, 5130, F8CA, DF90, 7C81, 1C24, 23B4, 628A.
- round_idx = k in 1..19 uses β(k-1).
- round_idx = 0 or 20..31 uses a zero constant, so RK = K (whitening key).
- All three functions are purely combinational; only the output stage is registered.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, state_out=0, sub_key=0 immediately. They stay so until the first rising edge after rst_n deasserts.
- Latency is 1 cycle. When in_valid=1 at edge N, state_out/sub_key are updated and out_valid=1 after edge N.
- Throughput is one operation per cycle; back-to-back in_valid is allowed with no bubbles.
- When in_valid=0 at an edge: out_valid goes to 0, and state_out/sub_key hold their previous values.
- No backpressure; the consumer must take results in the out_valid cycle.
- Reset asserted mid-stream discards the pending result. The first capture after release behaves exactly like a first-ever capture.
- Inputs need only be stable around the capturing edge; there is no internal state beyond the output registers.

## Test plan
- state_in=0, key=0, round_idx=1, in_valid=1 -> next cycle: out_valid=1, state_out = sub_key = 00000001000100010100010100000101.
- state_in=01000000000000000000000000000000 (cell 0 = 01), key=0, round_idx=0 -> state_out = 00010101000000000000000000000000, sub_key=0.
- state_in=00AB0000000000000000000000000000 (cell 1 = AB), key=0, round_idx=0 -> state_out = 00000000ABABAB000000000000000000.
- state_in all bytes 5A, key=0, round_idx=0 -> state_out all bytes 5A (column-uniform fixed point). Then round_idx=20 -> identical result with sub_key=0.
- state_in=0, key all FF, round_idx=19 -> sub_key = state_out = FFFEFEFFFFFFFEFFFEFFFFFFFEFFFEFF. Back-to-back with round_idx=1 on the next cycle -> out_valid stays 1 and the results update each cycle.
- In mid-stream, pulse rst_n low between edges -> out_valid, state_out and sub_key are 0 immediately. With in_valid=0 after release, the outputs stay 0. A new capture produces correct results one cycle later.
